// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
package mult_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/booth_multiplier_n.sv
// Combinational signed radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH.
module booth_multiplier_n #(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0]   m,
    input  logic signed [WIDTH-1:0]   q,
    output logic signed [2*WIDTH-1:0] p
);

    logic signed [2*WIDTH-1:0] m_ext;
    logic signed [2*WIDTH-1:0] acc;
    logic                      prev;

    assign m_ext = {{WIDTH{m[WIDTH-1]}}, m};

    // Scan multiplier bit pairs, adding or subtracting the shifted multiplicand.
    always_comb begin
        acc  = '0;
        prev = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            case ({q[i], prev})
                2'b01:   acc = acc + (m_ext <<< i);
                2'b10:   acc = acc - (m_ext <<< i);
                default: acc = acc;
            endcase
            prev = q[i];
        end
        p = acc;
    end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one Booth multiplier between two valid/ready
// requesters. Not pipelined: one request is accepted, computed and returned
// before the next is granted.
//
// state | meaning
// IDLE  | waiting for a request, grant is combinational
// CALC  | operand regs drive the multiplier, product captured on exit
// RESP  | product presented, waiting for the consumer
module mult_share_arb #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_req0_valid,
    output logic               o_req0_ready,
    input  logic [WIDTH-1:0]   i_req0_m,
    input  logic [WIDTH-1:0]   i_req0_q,
    input  logic               i_req1_valid,
    output logic               o_req1_ready,
    input  logic [WIDTH-1:0]   i_req1_m,
    input  logic [WIDTH-1:0]   i_req1_q,
    output logic               o_resp_valid,
    input  logic               i_resp_ready,
    output logic [2*WIDTH-1:0] o_resp_p,
    output logic               o_resp_id
);
    import mult_arb_pkg::*;

    state_t                    state;
    state_t                    state_nxt;
    logic                      prio;
    logic signed [WIDTH-1:0]   op_m;
    logic signed [WIDTH-1:0]   op_q;
    logic [ID_W-1:0]           op_id;
    logic signed [2*WIDTH-1:0] prod;
    logic                      req0_ready;
    logic                      req1_ready;
    logic                      accept;

    booth_multiplier_n #(.WIDTH(WIDTH)) u_mult (
        .m (op_m),
        .q (op_q),
        .p (prod)
    );

    assign o_req0_ready = req0_ready;
    assign o_req1_ready = req1_ready;
    assign accept       = req0_ready | req1_ready;

    // Next-state and grant; the last-served requester loses a tie, and
    // ready is held low while reset is asserted.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = i_req0_valid & (~prio | ~i_req1_valid) & ~i_reset;
                req1_ready = i_req1_valid & (prio | ~i_req0_valid) & ~i_reset;
                if (req0_ready | req1_ready) state_nxt = CALC;
            end
            CALC:    state_nxt = RESP;
            RESP:    if (i_resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Operand capture on grant, product capture in CALC, response valid flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            prio         <= 1'b0;
            op_m         <= '0;
            op_q         <= '0;
            op_id        <= '0;
            o_resp_p     <= '0;
            o_resp_id    <= 1'b0;
            o_resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_m  <= req0_ready ? i_req0_m : i_req1_m;
                        op_q  <= req0_ready ? i_req0_q : i_req1_q;
                        op_id <= ID_W'(req1_ready);
                        prio  <= req0_ready;
                    end
                end
                CALC: begin
                    o_resp_p     <= prod;
                    o_resp_id    <= op_id[0];
                    o_resp_valid <= 1'b1;
                end
                RESP: begin
                    if (i_resp_ready) o_resp_valid <= 1'b0;
                end
                default: o_resp_valid <= 1'b0;
            endcase
        end
    end

endmodule
